exec_dispatcher: RTL and testbench
==================================

EXEC_DISPATCHER -- requirements
Module: exec_dispatcher

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 64, is the maximum WAIT cycles before an operation is aborted (legal 2..65535).
REQ-002 Parameter: START_HOLD, default 2, is the number of cycles elem_reset stays high after operand latch (legal 1..15).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  decode stage offers an operation.
REQ-006 req_ready  output  1  dispatcher accepts the operation this cycle.
REQ-007 req_inst_num  input  6  opcode; req_const16_x input 32 immediate; req_shift5 input 5 shift amount.
REQ-008 req_rs, req_rt  input  32 each  source operand values.
REQ-009 req_dest  input  5  destination register tag, returned unchanged with the result.
REQ-010 elem_reset  output  1  active-high start/reset strobe to the exec element.
REQ-011 elem_inst_num 6, elem_const16_x 32, elem_shift5 5, elem_rs 32, elem_rt 32  outputs  latched operands to the element.
REQ-012 elem_completed  input  1  element result-valid level; elem_out input 32 element result.
REQ-013 wb_valid  output  1  write-back offer; wb_ready input 1 write-back accept.
REQ-014 wb_dest 5, wb_data 32, wb_error 1  outputs  write-back tag, result, timeout flag.
REQ-015 busy  output  1  high in any state other than IDLE; done_count output 16 completed-operation counter.

Function
REQ-016 States SHALL be IDLE, START, WAIT, WB, encoded in a single registered state variable.
REQ-017 IDLE: req_ready=1, elem_reset=1; req_valid&req_ready latches all req_* fields into the elem_* and destination registers and moves to START.
REQ-018 elem_* operand outputs SHALL stay constant from latch until the next accepted request.
REQ-019 START: elem_reset=1 for exactly START_HOLD cycles (hold counter), then WAIT.
REQ-020 WAIT: elem_reset=0; wait counter increments by 1 each cycle starting from 0 on entry.
REQ-021 Completion SHALL be a 0->1 transition of elem_completed sampled in WAIT (registered previous value); a level already high on WAIT entry is not a completion.
REQ-022 On completion: capture elem_out into wb_data, wb_error=0, go to WB.
REQ-023 If the wait counter reaches TIMEOUT_CYCLES-1 with no completion: wb_data=0, wb_error=1, go to WB.
REQ-024 Completion and timeout in the same cycle: completion wins (wb_error=0).
REQ-025 WB: wb_valid=1 with stable wb_dest/wb_data/wb_error until wb_ready=1; on wb_valid&wb_ready go to IDLE next cycle.
REQ-026 done_count increments by 1 on each WB handshake with wb_error=0, wrapping 0xFFFF->0x0000.
REQ-027 req_ready SHALL be 0 in START, WAIT, WB; no request is accepted in the WB handshake cycle.
REQ-028 Minimum issue-to-writeback latency: 1 (latch) + START_HOLD + element latency + 1 cycles.

Reset
REQ-029 reset=0 SHALL immediately force: state=IDLE, req_ready=1, elem_reset=1, elem_* operands=0, wb_valid=0, wb_dest=0, wb_data=0, wb_error=0, busy=0, done_count=0, all counters and previous-completed register=0.
REQ-030 Reset in any state SHALL abort the operation without a write-back; first request after release is accepted normally.

Verification
REQ-031 ADD: inst 8, rs=17, rt=255, dest=3, element completes 5 cycles into WAIT -> one wb_valid with wb_dest=3, wb_data=272, wb_error=0, done_count=1.
REQ-032 DIV: inst 12, rs=0x1234567, rt=0xDAB, wb_ready low 3 cycles -> wb_valid held 4 cycles, wb_data=5455 stable, single done_count increment.
REQ-033 Timeout: elem_completed tied 0, TIMEOUT_CYCLES=64 -> WB entered after 64 WAIT cycles, wb_error=1, wb_data=0, done_count unchanged.
REQ-034 Stale completion: elem_completed held 1 through START into WAIT, then never toggles -> no completion, timeout path taken.
REQ-035 Back-to-back: req_valid held high with SLL (inst 16, shift5=15) then SRA (inst 17) -> second request accepted only in IDLE after first WB handshake; elem_reset high START_HOLD cycles each.
REQ-036 Reset mid-WAIT: reset=0 for 1 cycle at WAIT cycle 3 -> all outputs at REQ-029 values immediately, no wb_valid pulse for the aborted operation.

Source files
------------

// File: rtl/exec_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : exec_dispatcher
// Description : Single-issue dispatcher between a decode stage and one
//               execution element. It accepts one operation at a time and
//               latches its operands. It strobes the element with
//               elem_reset for a fixed number of cycles, then waits for a
//               rising edge of elem_completed or a timeout. The result (or
//               a timeout error) is offered on a valid/ready write-back port.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   TIMEOUT_CYCLES : WAIT cycles allowed before an operation is aborted
//                    (2..65535)
//   START_HOLD     : cycles elem_reset stays high after the operand latch
//                    (1..15)
// Ports
//   clk, reset            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake from decode
//   req_inst_num, req_const16_x, req_shift5, req_rs, req_rt, req_dest
//                         : operation fields and destination tag
//   elem_reset            : start/reset strobe to the element (active high)
//   elem_inst_num, elem_const16_x, elem_shift5, elem_rs, elem_rt
//                         : latched operands to the element
//   elem_completed, elem_out : element result-valid level and result
//   wb_valid/wb_ready     : write-back handshake
//   wb_dest, wb_data, wb_error : write-back tag, result, timeout flag
//   busy                  : high whenever not idle
//   done_count            : count of error-free completed write-backs
// ============================================================================
module exec_dispatcher #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int START_HOLD     = 2
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  req_inst_num,
    input  logic [31:0] req_const16_x,
    input  logic [4:0]  req_shift5,
    input  logic [31:0] req_rs,
    input  logic [31:0] req_rt,
    input  logic [4:0]  req_dest,

    output logic        elem_reset,
    output logic [5:0]  elem_inst_num,
    output logic [31:0] elem_const16_x,
    output logic [4:0]  elem_shift5,
    output logic [31:0] elem_rs,
    output logic [31:0] elem_rt,
    input  logic        elem_completed,
    input  logic [31:0] elem_out,

    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_dest,
    output logic [31:0] wb_data,
    output logic        wb_error,

    output logic        busy,
    output logic [15:0] done_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_WB    = 2'd3
    } state_t;

    localparam logic [3:0]  HOLD_LAST    = 4'(START_HOLD - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t      state_q,        state_d;
    logic [3:0]  hold_cnt_q,     hold_cnt_d;
    logic [15:0] wait_cnt_q,     wait_cnt_d;
    logic        comp_prev_q,    comp_prev_d;

    logic [5:0]  inst_num_q,     inst_num_d;
    logic [31:0] const16_x_q,    const16_x_d;
    logic [4:0]  shift5_q,       shift5_d;
    logic [31:0] rs_q,           rs_d;
    logic [31:0] rt_q,           rt_d;
    logic [4:0]  dest_q,         dest_d;

    logic [31:0] wb_data_q,      wb_data_d;
    logic        wb_error_q,     wb_error_d;
    logic [15:0] done_count_q,   done_count_d;

    // Control outputs are registered copies of the next-state decode so
    // they change cleanly on the clock edge together with the state.
    logic        req_ready_q,    req_ready_d;
    logic        elem_reset_q,   elem_reset_d;
    logic        wb_valid_q,     wb_valid_d;
    logic        busy_q,         busy_d;

    // A completion is only the rising edge of the element's level; a level
    // already high when WAIT is entered was left over and is ignored.
    logic        completion;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        comp_prev_d  = elem_completed;
        inst_num_d   = inst_num_q;
        const16_x_d  = const16_x_q;
        shift5_d     = shift5_q;
        rs_d         = rs_q;
        rt_d         = rt_q;
        dest_d       = dest_q;
        wb_data_d    = wb_data_q;
        wb_error_d   = wb_error_q;
        done_count_d = done_count_q;

        completion   = elem_completed & ~comp_prev_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    inst_num_d  = req_inst_num;
                    const16_x_d = req_const16_x;
                    shift5_d    = req_shift5;
                    rs_d        = req_rs;
                    rt_d        = req_rt;
                    dest_d      = req_dest;
                    hold_cnt_d  = 4'd0;
                    state_d     = S_START;
                end
            end

            S_START: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    wait_cnt_d = 16'd0;
                    state_d    = S_WAIT;
                end else begin
                    hold_cnt_d = hold_cnt_q + 4'd1;
                end
            end

            S_WAIT: begin
                // Completion is tested first so it wins over a timeout
                // landing in the same cycle.
                if (completion) begin
                    wb_data_d  = elem_out;
                    wb_error_d = 1'b0;
                    state_d    = S_WB;
                end else if (wait_cnt_q == TIMEOUT_LAST) begin
                    wb_data_d  = 32'd0;
                    wb_error_d = 1'b1;
                    state_d    = S_WB;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end

            S_WB: begin
                if (wb_ready) begin
                    if (!wb_error_q) begin
                        done_count_d = done_count_q + 16'd1;
                    end
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        req_ready_d  = (state_d == S_IDLE);
        elem_reset_d = (state_d == S_IDLE) || (state_d == S_START);
        wb_valid_d   = (state_d == S_WB);
        busy_d       = (state_d != S_IDLE);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hold_cnt_q   <= 4'd0;
            wait_cnt_q   <= 16'd0;
            comp_prev_q  <= 1'b0;
            inst_num_q   <= 6'd0;
            const16_x_q  <= 32'd0;
            shift5_q     <= 5'd0;
            rs_q         <= 32'd0;
            rt_q         <= 32'd0;
            dest_q       <= 5'd0;
            wb_data_q    <= 32'd0;
            wb_error_q   <= 1'b0;
            done_count_q <= 16'd0;
            req_ready_q  <= 1'b1;
            elem_reset_q <= 1'b1;
            wb_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            comp_prev_q  <= comp_prev_d;
            inst_num_q   <= inst_num_d;
            const16_x_q  <= const16_x_d;
            shift5_q     <= shift5_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            dest_q       <= dest_d;
            wb_data_q    <= wb_data_d;
            wb_error_q   <= wb_error_d;
            done_count_q <= done_count_d;
            req_ready_q  <= req_ready_d;
            elem_reset_q <= elem_reset_d;
            wb_valid_q   <= wb_valid_d;
            busy_q       <= busy_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign req_ready      = req_ready_q;
    assign elem_reset     = elem_reset_q;
    assign elem_inst_num  = inst_num_q;
    assign elem_const16_x = const16_x_q;
    assign elem_shift5    = shift5_q;
    assign elem_rs        = rs_q;
    assign elem_rt        = rt_q;
    assign wb_valid       = wb_valid_q;
    assign wb_dest        = dest_q;
    assign wb_data        = wb_data_q;
    assign wb_error       = wb_error_q;
    assign busy           = busy_q;
    assign done_count     = done_count_q;

endmodule
`default_nettype wire

// File: tb/tb_exec_dispatcher.sv
`default_nettype none
// ============================================================================
// Module      : tb_exec_dispatcher
// Description : Bench for exec_dispatcher. A behavioural execution element
//               and a scoreboard of expected write-backs sit alongside
//               directed and randomised request streams.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_exec_dispatcher;

    localparam int TO = 64;
    localparam int SH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [5:0]  req_inst_num = '0;
    logic [31:0] req_const16_x = '0;
    logic [4:0]  req_shift5 = '0;
    logic [31:0] req_rs = '0;
    logic [31:0] req_rt = '0;
    logic [4:0]  req_dest = '0;
    logic        elem_reset;
    logic [5:0]  elem_inst_num;
    logic [31:0] elem_const16_x;
    logic [4:0]  elem_shift5;
    logic [31:0] elem_rs;
    logic [31:0] elem_rt;
    logic        elem_completed = 1'b0;
    logic [31:0] elem_out = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic        wb_error;
    logic        busy;
    logic [15:0] done_count;

    always #5 clk = ~clk;

    exec_dispatcher #(.TIMEOUT_CYCLES(TO), .START_HOLD(SH)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_inst_num(req_inst_num), .req_const16_x(req_const16_x),
        .req_shift5(req_shift5), .req_rs(req_rs), .req_rt(req_rt),
        .req_dest(req_dest),
        .elem_reset(elem_reset), .elem_inst_num(elem_inst_num),
        .elem_const16_x(elem_const16_x), .elem_shift5(elem_shift5),
        .elem_rs(elem_rs), .elem_rt(elem_rt),
        .elem_completed(elem_completed), .elem_out(elem_out),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest),
        .wb_data(wb_data), .wb_error(wb_error),
        .busy(busy), .done_count(done_count)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] data;
        logic        err;
        int          stall;
    } exp_t;

    exp_t        sb[$];
    int          pend_lat = 0, pend_stall = 0;
    bit          pend_stale = 1'b0;
    int          cur_lat = 0;
    bit          cur_stale = 1'b0;
    int          elem_cyc = 0;
    int          wb_cyc = 0;
    bit          acc_flag = 1'b0;
    bit          in_start = 1'b0;
    int          hold_seen = 0;
    logic [15:0] model_done = '0;

    // Architectural meaning of each opcode, used both by the element model
    // (from the latched operands) and by the reference (from the request).
    function automatic logic [31:0] op_fn(input logic [5:0] inst, input logic [31:0] rs,
                                          input logic [31:0] rt, input logic [4:0] sh,
                                          input logic [31:0] k);
        logic [31:0] r;
        case (inst)
            6'd8:    r = rs + rt;
            6'd12:   r = (rt != 0) ? rs / rt : 32'd0;
            6'd16:   r = rt << sh;
            6'd17:   r = $signed(rt) >>> sh;
            default: r = rs ^ k;
        endcase
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Element model, acceptance tracker and write-back monitor, all on the
    // falling edge so every sample is away from the DUT's active edge.
    always @(negedge clk) begin
        if (!reset) begin
            elem_completed = 1'b0;
            elem_cyc       = 0;
            wb_cyc         = 0;
            in_start       = 1'b0;
            wb_ready       = 1'b0;
        end else begin
            check("req_ready_vs_busy", req_ready, !busy);

            if (req_valid && req_ready) begin
                exp_t e;
                check("accept_only_when_empty", sb.size(), 0);
                e.dest  = req_dest;
                e.err   = pend_stale || (pend_lat > TO - 1);
                e.data  = e.err ? 32'd0
                                : op_fn(req_inst_num, req_rs, req_rt, req_shift5, req_const16_x);
                e.stall = pend_stall;
                sb.push_back(e);
                cur_lat   = pend_lat;
                cur_stale = pend_stale;
                acc_flag  = 1'b1;
                in_start  = 1'b1;
                hold_seen = 0;
            end else if (in_start) begin
                if (elem_reset) hold_seen++;
                else begin
                    check("start_hold_cycles", hold_seen, SH);
                    in_start = 1'b0;
                end
            end

            if (elem_reset) begin
                elem_cyc       = 0;
                elem_completed = cur_stale;
                elem_out       = $urandom;
            end else begin
                if (!cur_stale && elem_cyc >= cur_lat) begin
                    elem_completed = 1'b1;
                    elem_out = op_fn(elem_inst_num, elem_rs, elem_rt, elem_shift5, elem_const16_x);
                end else begin
                    elem_completed = cur_stale;
                    elem_out       = $urandom;
                end
                elem_cyc++;
            end

            if (wb_valid) begin
                if (sb.size() == 0) begin
                    wb_ready = 1'b1;
                    check("unexpected_wb_valid", wb_valid, 1'b0);
                end else begin
                    wb_ready = (wb_cyc >= sb[0].stall);
                    check("wb_dest", wb_dest, sb[0].dest);
                    check("wb_data", wb_data, sb[0].data);
                    check("wb_error", wb_error, sb[0].err);
                    check("done_count", done_count, model_done);
                    if (wb_ready) begin
                        if (!sb[0].err) model_done++;
                        void'(sb.pop_front());
                        wb_cyc = 0;
                    end else begin
                        wb_cyc++;
                    end
                end
            end else begin
                wb_ready = $urandom_range(0, 1);
                wb_cyc   = 0;
            end
        end
    end

    task automatic issue(input logic [5:0] inst, input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] k, input logic [4:0] sh, input logic [4:0] dest,
                         input int lat, input bit stale, input int stall);
        bit got = 1'b0;
        req_inst_num  = inst;
        req_rs        = rs;
        req_rt        = rt;
        req_const16_x = k;
        req_shift5    = sh;
        req_dest      = dest;
        pend_lat      = lat;
        pend_stale    = stale;
        pend_stall    = stall;
        acc_flag      = 1'b0;
        req_valid     = 1'b1;
        for (int i = 0; i < 600 && !got; i++) begin
            @(posedge clk);
            if (acc_flag) got = 1'b1;
        end
        #1;
        if (!got) begin
            n_total++;
            $display("FAIL issue_accept: request not accepted within 600 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        req_valid = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !busy && !wb_valid) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        if (!ok) begin
            n_total++;
            $display("FAIL wait_idle: %0d write-backs still outstanding", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_reset_values();
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_elem_reset", elem_reset, 1'b1);
        check("rst_elem_ops", {elem_inst_num, elem_shift5} | elem_rs | elem_rt | elem_const16_x, 32'd0);
        check("rst_wb_valid", wb_valid, 1'b0);
        check("rst_wb_dest", wb_dest, 5'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_wb_error", wb_error, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done_count", done_count, 16'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [5:0] ops [5];
        ops[0] = 6'd8; ops[1] = 6'd12; ops[2] = 6'd16; ops[3] = 6'd17; ops[4] = 6'd5;

        #12;
        check_reset_values();
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #1;

        // ADD, element completes 5 cycles into WAIT
        issue(6'd8, 32'd17, 32'd255, 32'd0, 5'd0, 5'd3, 5, 1'b0, 0);
        wait_idle();
        check("add_done_count", done_count, 16'd1);

        // DIV with write-back stalled for three cycles
        issue(6'd12, 32'h0123_4567, 32'h0000_0DAB, 32'd0, 5'd0, 5'd9, 7, 1'b0, 3);
        wait_idle();
        check("div_done_count", done_count, 16'd2);

        // Timeout: element never completes
        issue(6'd8, 32'd1, 32'd2, 32'd0, 5'd0, 5'd4, 1000, 1'b0, 1);
        wait_idle();
        check("timeout_done_count", done_count, 16'd2);

        // Stale completion level carried into WAIT
        issue(6'd8, 32'd5, 32'd6, 32'd0, 5'd0, 5'd5, 1000, 1'b1, 0);
        wait_idle();

        // Completion exactly at, and just past, the timeout boundary
        issue(6'd8, 32'd10, 32'd20, 32'd0, 5'd0, 5'd6, TO - 2, 1'b0, 0);
        req_valid = 1'b0;
        issue(6'd8, 32'd11, 32'd21, 32'd0, 5'd0, 5'd7, TO - 1, 1'b0, 0);
        req_valid = 1'b0;
        issue(6'd8, 32'd12, 32'd22, 32'd0, 5'd0, 5'd8, TO, 1'b0, 0);
        wait_idle();

        // Back-to-back SLL then SRA with req_valid held high
        issue(6'd16, 32'd0, 32'h0000_00A5, 32'd0, 5'd15, 5'd10, 3, 1'b0, 0);
        issue(6'd17, 32'd0, 32'h8000_1234, 32'd0, 5'd4, 5'd11, 2, 1'b0, 1);
        wait_idle();

        // Randomised stream
        for (int n = 0; n < 30; n++) begin
            int r, lat;
            r = $urandom_range(0, 9);
            if (r < 6)       lat = $urandom_range(0, 19);
            else if (r == 6) lat = $urandom_range(TO - 2, TO);
            else if (r == 7) lat = 200;
            else             lat = $urandom_range(0, 7);
            issue(ops[$urandom_range(0, 4)], $urandom, $urandom, $urandom,
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  lat, ($urandom_range(0, 7) == 0), $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) begin
                req_valid = 1'b0;
                repeat ($urandom_range(0, 2)) @(posedge clk);
                #1;
            end
        end
        wait_idle();

        // Reset during WAIT cycle 3 aborts the operation silently
        issue(6'd8, 32'd100, 32'd200, 32'd0, 5'd0, 5'd12, 20, 1'b0, 0);
        req_valid = 1'b0;
        begin
            bit in_wait = 1'b0;
            for (int i = 0; i < 50 && !in_wait; i++) begin
                @(negedge clk);
                if (!elem_reset && busy) in_wait = 1'b1;
            end
            check("reached_wait", in_wait, 1'b1);
        end
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        sb.delete();
        model_done = '0;
        check_reset_values();
        @(posedge clk); #2;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_wb_valid", wb_valid, 1'b0);
        @(posedge clk); #1;

        // First request after reset is accepted normally
        issue(6'd8, 32'd40, 32'd2, 32'd0, 5'd0, 5'd13, 4, 1'b0, 0);
        wait_idle();
        check("post_reset_done_count", done_count, 16'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
